// File: rtl/lock_sequencer.sv
// lock_sequencer: combination-lock sequencing controller with a programmable
// 4-digit code, failed-attempt counting, timed unlock window and entry timeout.
//
// Build option: define LOCK_LOCKOUT_EN to make MAX_TRIES consecutive failures
// enter a timed LOCKOUT that returns to IDLE. Without it the same event
// latches a terminal ALARM that only reset_n clears.
//
// state        | meaning
// -------------|-----------------------------------------------------------
// ST_IDLE      | locked; collecting a 4-digit entry
// ST_UNLOCKED  | open; relocks after UNLOCK_CYCLES unless prog is seen
// ST_PROG      | collecting 4 digits for a new code
// ST_LOCKOUT   | presses ignored for LOCKOUT_CYCLES, then back to IDLE
// ST_ALARM     | terminal; only reset_n leaves
module lock_sequencer #(
  parameter logic [11:0] DEFAULT_CODE   = 12'h688,
  parameter int          UNLOCK_CYCLES  = 300,
  parameter int          ENTRY_TIMEOUT  = 500,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 1000
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [7:0]                         switches,
  input  logic                               prog,
  output logic                               locked,
  output logic                               alarm,
  output logic                               lockout,
  output logic [1:0]                         digit_idx,
  output logic [$clog2(MAX_TRIES+1)-1:0]     fail_count
);

  localparam int FC_W  = $clog2(MAX_TRIES + 1);
  localparam int CMAX0 = (UNLOCK_CYCLES > ENTRY_TIMEOUT) ? UNLOCK_CYCLES : ENTRY_TIMEOUT;
  localparam int CMAX  = (CMAX0 > LOCKOUT_CYCLES) ? CMAX0 : LOCKOUT_CYCLES;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

  // The timer is loaded with N-1 and the exit happens on the edge that sees
  // zero, so the state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] UNL_LOAD = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(ENTRY_TIMEOUT - 1);
`ifdef LOCK_LOCKOUT_EN
  localparam logic [CNT_W-1:0] LCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNLOCKED,
    ST_PROG,
    ST_LOCKOUT,
    ST_ALARM
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        sw_q;
  logic [7:0]        rise;
  logic              press, valid, mism;
  logic [2:0]        digit, exp_digit;
  logic [11:0]       code, code_nxt;
  logic [8:0]        shadow, shadow_nxt;
  logic [CNT_W-1:0]  tmr, tmr_nxt;
  logic              tmr_zero;
  logic [1:0]        idx_nxt;
  logic [FC_W-1:0]   fail_nxt, fail_inc;
  logic              bad, bad_nxt;

  assign rise     = switches & ~sw_q;
  assign press    = |rise;
  assign valid    = $onehot(rise);
  assign tmr_zero = (tmr == '0);
  assign fail_inc = fail_count + 1'b1;
  assign mism     = !valid || (digit != exp_digit);

  // Encode the rising switch into a digit value (meaningful only when valid).
  always_comb begin
    digit = '0;
    for (int i = 0; i < 8; i++) begin
      if (rise[i]) digit = 3'(i);
    end
  end

  // Select the stored digit the current entry position must match.
  always_comb begin
    case (digit_idx)
      2'd0:    exp_digit = code[2:0];
      2'd1:    exp_digit = code[5:3];
      2'd2:    exp_digit = code[8:6];
      default: exp_digit = code[11:9];
    endcase
  end

  // Next-state, counter and datapath decisions for the sequencer.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = digit_idx;
    bad_nxt    = bad;
    fail_nxt   = fail_count;
    code_nxt   = code;
    shadow_nxt = shadow;
    tmr_nxt    = tmr_zero ? tmr : tmr - 1'b1;

    case (state)
      ST_IDLE: begin
        if (press) begin
          tmr_nxt = TMO_LOAD;
          if (digit_idx == 2'd3) begin
            idx_nxt = '0;
            bad_nxt = 1'b0;
            if (!(bad || mism)) begin
              state_nxt = ST_UNLOCKED;
              fail_nxt  = '0;
              tmr_nxt   = UNL_LOAD;
            end else begin
              fail_nxt = fail_inc;
              if (fail_inc == FC_W'(MAX_TRIES)) begin
`ifdef LOCK_LOCKOUT_EN
                state_nxt = ST_LOCKOUT;
                tmr_nxt   = LCK_LOAD;
`else
                state_nxt = ST_ALARM;
`endif
              end
            end
          end else begin
            idx_nxt = digit_idx + 1'b1;
            bad_nxt = bad | mism;
          end
        end else if (digit_idx != 2'd0 && tmr_zero) begin
          idx_nxt = '0;
          bad_nxt = 1'b0;
        end
      end

      ST_UNLOCKED: begin
        if (prog) begin
          state_nxt = ST_PROG;
          idx_nxt   = '0;
          tmr_nxt   = TMO_LOAD;
        end else if (tmr_zero) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
          bad_nxt   = 1'b0;
          tmr_nxt   = TMO_LOAD;
        end
      end

      ST_PROG: begin
        if (press) begin
          tmr_nxt = TMO_LOAD;
          if (!valid) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
          end else begin
            case (digit_idx)
              2'd0:    shadow_nxt[2:0] = digit;
              2'd1:    shadow_nxt[5:3] = digit;
              2'd2:    shadow_nxt[8:6] = digit;
              default: code_nxt        = {digit, shadow};
            endcase
            if (digit_idx == 2'd3) begin
              state_nxt = ST_IDLE;
              idx_nxt   = '0;
            end else begin
              idx_nxt = digit_idx + 1'b1;
            end
          end
        end else if (digit_idx != 2'd0 && tmr_zero) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
          tmr_nxt   = TMO_LOAD;
        end
      end

`ifdef LOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (tmr_zero) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
          bad_nxt   = 1'b0;
          fail_nxt  = '0;
          tmr_nxt   = TMO_LOAD;
        end
      end
`endif

      ST_ALARM: begin
        state_nxt = ST_ALARM;
      end

      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
        bad_nxt   = 1'b0;
        tmr_nxt   = TMO_LOAD;
      end
    endcase
  end

  // State, datapath and registered locked decode.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sw_q       <= '0;
      code       <= DEFAULT_CODE;
      shadow     <= '0;
      tmr        <= TMO_LOAD;
      digit_idx  <= '0;
      fail_count <= '0;
      bad        <= 1'b0;
      locked     <= 1'b1;
    end else begin
      state      <= state_nxt;
      sw_q       <= switches;
      code       <= code_nxt;
      shadow     <= shadow_nxt;
      tmr        <= tmr_nxt;
      digit_idx  <= idx_nxt;
      fail_count <= fail_nxt;
      bad        <= bad_nxt;
      locked     <= (state_nxt != ST_UNLOCKED);
    end
  end

`ifdef LOCK_LOCKOUT_EN
  // Lockout flag is a registered decode of the state; alarm cannot occur.
  always_ff @(posedge clock) begin
    if (!reset_n) lockout <= 1'b0;
    else          lockout <= (state_nxt == ST_LOCKOUT);
  end
  assign alarm = 1'b0;
`else
  // Alarm flag is a registered decode of the terminal state; no lockout.
  always_ff @(posedge clock) begin
    if (!reset_n) alarm <= 1'b0;
    else          alarm <= (state_nxt == ST_ALARM);
  end
  assign lockout = 1'b0;
`endif

endmodule

// File: tb/tb_lock_sequencer.sv
// Testbench for lock_sequencer: randomized entries checked against a
// code-sequence model of the lock.
module tb_lock_sequencer;

  localparam int UNL  = 8;
  localparam int LCK  = 16;
  localparam int TMO  = 10;
  localparam int MAXT = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] switches = '0;
  logic       prog = 1'b0;
  logic       locked, alarm, lockout;
  logic [1:0] digit_idx;
  logic [1:0] fail_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the stored code as digit values, and the failure tally.
  logic [2:0] mcode [4];
  int         mfail;
  // Switch vectors of the entry about to be pressed.
  logic [7:0] seq [4];

  lock_sequencer #(
    .DEFAULT_CODE  (12'h688),
    .UNLOCK_CYCLES (UNL),
    .ENTRY_TIMEOUT (TMO),
    .MAX_TRIES     (MAXT),
    .LOCKOUT_CYCLES(LCK)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .switches  (switches),
    .prog      (prog),
    .locked    (locked),
    .alarm     (alarm),
    .lockout   (lockout),
    .digit_idx (digit_idx),
    .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One-cycle pulse; returns right after the edge that consumed it.
  task automatic press(input logic [7:0] v);
    switches = v;
    @(negedge clock);
    switches = '0;
  endtask

  task automatic model_default();
    mcode[0] = 3'd0; mcode[1] = 3'd1; mcode[2] = 3'd2; mcode[3] = 3'd3;
    mfail = 0;
  endtask

  task automatic set_seq_code();
    for (int k = 0; k < 4; k++) seq[k] = 8'd1 << mcode[k];
  endtask

  task automatic make_wrong();
    int p;
    logic [2:0] d;
    set_seq_code();
    p = $urandom_range(0, 3);
    if ($urandom_range(0, 1) == 1) begin
      seq[p] = 8'h03 << $urandom_range(0, 6);
    end else begin
      d = mcode[p] + 3'($urandom_range(1, 7));
      seq[p] = 8'd1 << d;
    end
  endtask

  function automatic bit model_accepts();
    for (int k = 0; k < 4; k++)
      if (seq[k] !== (8'd1 << mcode[k])) return 1'b0;
    return 1'b1;
  endfunction

  // Presses seq with random idle gaps shorter than the entry timeout.
  task automatic entry();
    for (int k = 0; k < 4; k++) begin
      tick(1 + $urandom_range(0, 6));
      press(seq[k]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    prog = 1'b0;
    for (int i = 0; i < 3; i++) begin
      switches = 8'($urandom);
      tick(1);
    end
    switches = '0;
    tick(1);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL reset_locked: got %0b want 1", locked); end
    n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL reset_alarm: got %0b want 0", alarm); end
    n_checks++; if (lockout !== 1'b0) begin n_fail++; $display("FAIL reset_lockout: got %0b want 0", lockout); end
    n_checks++; if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", digit_idx); end
    n_checks++; if (fail_count !== 2'd0) begin n_fail++; $display("FAIL reset_fail: got %0d want 0", fail_count); end
    reset_n = 1'b1;
    model_default();
    tick(2);
    n_checks++; if (locked !== 1'b1 || digit_idx !== 2'd0) begin n_fail++; $display("FAIL post_reset: locked=%0b idx=%0d want 1/0", locked, digit_idx); end
  endtask

  task automatic test_correct_entry();
    int low;
    set_seq_code();
    // first digit held for three cycles must count once
    switches = seq[0];
    tick(3);
    switches = '0;
    n_checks++; if (digit_idx !== 2'd1) begin n_fail++; $display("FAIL held_press_idx: got %0d want 1", digit_idx); end
    tick(2);
    press(seq[1]);
    tick(2);
    n_checks++; if (digit_idx !== 2'd2) begin n_fail++; $display("FAIL release_no_event: got %0d want 2", digit_idx); end
    press(seq[2]);
    tick(1);
    press(seq[3]);
    n_checks++; if (locked !== !model_accepts()) begin n_fail++; $display("FAIL unlock_latency: locked=%0b want %0b", locked, !model_accepts()); end
    n_checks++; if (fail_count !== 2'd0) begin n_fail++; $display("FAIL unlock_fail_count: got %0d want 0", fail_count); end
    low = 0;
    while (locked === 1'b0 && low < 50) begin
      low++;
      tick(1);
    end
    n_checks++; if (low != UNL) begin n_fail++; $display("FAIL unlock_window: got %0d cycles want %0d", low, UNL); end
    mfail = 0;
  endtask

  task automatic test_wrong_entry();
    bit exp;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin set_seq_code(); seq[1] = 8'h20; end
      else if (it == 1) begin set_seq_code(); seq[0] = 8'h03; end
      else make_wrong();
      entry();
      exp = model_accepts();
      mfail = exp ? 0 : mfail + 1;
      n_checks++; if (locked !== !exp) begin n_fail++; $display("FAIL wrong_locked[%0d]: got %0b want %0b", it, locked, !exp); end
      n_checks++; if (fail_count !== 2'(mfail)) begin n_fail++; $display("FAIL wrong_fail_count[%0d]: got %0d want %0d", it, fail_count, mfail); end
      n_checks++; if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL wrong_idx[%0d]: got %0d want 0", it, digit_idx); end
      if (exp) tick(UNL);
      if (mfail == MAXT - 1) begin
        set_seq_code();
        entry();
        n_checks++; if (locked !== 1'b0 || fail_count !== 2'd0) begin n_fail++; $display("FAIL clear_after_wrong: locked=%0b fail=%0d want 0/0", locked, fail_count); end
        mfail = 0;
        tick(UNL);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock_after_clear: got %0b want 1", locked); end
      end
    end
  endtask

  task automatic test_timeout();
    set_seq_code();
    tick(1);
    press(seq[0]);
    tick(1);
    press(seq[1]);
    n_checks++; if (digit_idx !== 2'd2) begin n_fail++; $display("FAIL tmo_start_idx: got %0d want 2", digit_idx); end
    tick(TMO - 1);
    n_checks++; if (digit_idx !== 2'd2) begin n_fail++; $display("FAIL tmo_early: got %0d want 2", digit_idx); end
    tick(1);
    n_checks++; if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL tmo_expire: got %0d want 0", digit_idx); end
    n_checks++; if (fail_count !== 2'(mfail)) begin n_fail++; $display("FAIL tmo_fail_count: got %0d want %0d", fail_count, mfail); end
    entry();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL tmo_then_unlock: got %0b want 0", locked); end
    mfail = 0;
    tick(UNL);
  endtask

  task automatic test_prog_timeout();
    set_seq_code();
    entry();
    tick(1);
    prog = 1'b1;
    tick(1);
    prog = 1'b0;
    press(8'd1 << $urandom_range(0, 7));
    tick(2);
    press(8'd1 << $urandom_range(0, 7));
    tick(TMO - 1);
    n_checks++; if (digit_idx !== 2'd2) begin n_fail++; $display("FAIL prog_tmo_early: got %0d want 2", digit_idx); end
    tick(1);
    n_checks++; if (digit_idx !== 2'd0 || locked !== 1'b1) begin n_fail++; $display("FAIL prog_tmo_expire: idx=%0d locked=%0b want 0/1", digit_idx, locked); end
    set_seq_code();
    entry();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL prog_tmo_code_kept: got %0b want 0", locked); end
    tick(UNL);
  endtask

  task automatic test_programming();
    logic [2:0] oldc [4];
    logic [2:0] newc [4];
    bit exp;
    for (int it = 0; it < 2; it++) begin
      set_seq_code();
      entry();
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL prog_unlock[%0d]: got %0b want 0", it, locked); end
      prog = 1'b1;
      tick(1);
      n_checks++; if (locked !== 1'b1 || digit_idx !== 2'd0) begin n_fail++; $display("FAIL prog_enter[%0d]: locked=%0b idx=%0d want 1/0", it, locked, digit_idx); end
      for (int k = 0; k < 4; k++) begin
        oldc[k] = mcode[k];
        newc[k] = (it == 0) ? 3'(7 - k) : 3'($urandom_range(0, 7));
        seq[k]  = 8'd1 << newc[k];
      end
      entry();
      prog = 1'b0;
      for (int k = 0; k < 4; k++) mcode[k] = newc[k];
      n_checks++; if (locked !== 1'b1 || digit_idx !== 2'd0) begin n_fail++; $display("FAIL prog_done[%0d]: locked=%0b idx=%0d want 1/0", it, locked, digit_idx); end
      for (int k = 0; k < 4; k++) seq[k] = 8'd1 << oldc[k];
      entry();
      exp = model_accepts();
      mfail = exp ? 0 : mfail + 1;
      n_checks++; if (locked !== !exp) begin n_fail++; $display("FAIL prog_old_code[%0d]: locked=%0b want %0b", it, locked, !exp); end
      if (exp) tick(UNL);
      set_seq_code();
      entry();
      n_checks++; if (locked !== 1'b0 || fail_count !== 2'd0) begin n_fail++; $display("FAIL prog_new_code[%0d]: locked=%0b fail=%0d want 0/0", it, locked, fail_count); end
      mfail = 0;
      tick(UNL);
    end
  endtask

  task automatic test_prog_abort();
    set_seq_code();
    entry();
    tick(1);
    prog = 1'b1;
    tick(1);
    prog = 1'b0;
    tick(1);
    press(8'd1 << $urandom_range(0, 7));
    tick(1);
    press(8'd1 << $urandom_range(0, 7));
    tick(1);
    press(8'h11);
    n_checks++; if (digit_idx !== 2'd0 || locked !== 1'b1) begin n_fail++; $display("FAIL prog_abort: idx=%0d locked=%0b want 0/1", digit_idx, locked); end
    set_seq_code();
    entry();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL prog_abort_code_kept: got %0b want 0", locked); end
    tick(UNL);
  endtask

  task automatic test_reset_mid_prog();
    set_seq_code();
    entry();
    prog = 1'b1;
    tick(1);
    prog = 1'b0;
    press(8'd1 << $urandom_range(0, 7));
    tick(1);
    press(8'd1 << $urandom_range(0, 7));
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    model_default();
    tick(1);
    n_checks++; if (digit_idx !== 2'd0 || locked !== 1'b1) begin n_fail++; $display("FAIL mid_prog_reset: idx=%0d locked=%0b want 0/1", digit_idx, locked); end
    set_seq_code();
    entry();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_prog_default_code: got %0b want 0", locked); end
    tick(UNL);
  endtask

  task automatic test_held_at_release();
    set_seq_code();
    reset_n = 1'b0;
    switches = seq[0];
    tick(2);
    reset_n = 1'b1;
    tick(1);
    n_checks++; if (digit_idx !== 2'd1) begin n_fail++; $display("FAIL held_at_release: got %0d want 1", digit_idx); end
    switches = '0;
    for (int k = 1; k < 4; k++) begin
      tick(1 + $urandom_range(0, 4));
      press(seq[k]);
    end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL held_release_unlock: got %0b want 0", locked); end
    tick(UNL);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL held_release_relock: got %0b want 1", locked); end
  endtask

  task automatic test_lockout();
    int cyc;
    for (int i = 0; i < MAXT; i++) begin
      make_wrong();
      entry();
      mfail = model_accepts() ? 0 : mfail + 1;
      if (i < MAXT - 1) begin
        n_checks++; if (fail_count !== 2'(mfail) || alarm !== 1'b0 || lockout !== 1'b0) begin n_fail++; $display("FAIL pre_lockout[%0d]: fail=%0d alarm=%0b lockout=%0b want %0d/0/0", i, fail_count, alarm, lockout, mfail); end
      end
    end
    set_seq_code();
`ifdef LOCK_LOCKOUT_EN
    n_checks++; if (fail_count !== 2'(mfail) || alarm !== 1'b0) begin n_fail++; $display("FAIL lockout_entry: fail=%0d alarm=%0b want %0d/0", fail_count, alarm, mfail); end
    cyc = 0;
    while (lockout === 1'b1 && cyc < 60) begin
      cyc++;
      switches = (cyc % 2 == 1) ? seq[(cyc / 2) % 4] : 8'h00;
      tick(1);
    end
    switches = '0;
    n_checks++; if (cyc != LCK) begin n_fail++; $display("FAIL lockout_length: got %0d cycles want %0d", cyc, LCK); end
    n_checks++; if (fail_count !== 2'd0 || digit_idx !== 2'd0 || locked !== 1'b1) begin n_fail++; $display("FAIL lockout_exit: fail=%0d idx=%0d locked=%0b want 0/0/1", fail_count, digit_idx, locked); end
    mfail = 0;
    entry();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL post_lockout_unlock: got %0b want 0", locked); end
    tick(UNL);
`else
    n_checks++; if (alarm !== 1'b1 || fail_count !== 2'(mfail)) begin n_fail++; $display("FAIL alarm_entry: alarm=%0b fail=%0d want 1/%0d", alarm, fail_count, mfail); end
    n_checks++; if (lockout !== 1'b0) begin n_fail++; $display("FAIL alarm_lockout_tied: got %0b want 0", lockout); end
    cyc = 0;
    for (int i = 0; i < 24; i++) begin
      switches = (i % 2 == 0) ? seq[(i / 2) % 4] : 8'h00;
      tick(1);
      if (alarm !== 1'b1 || locked !== 1'b1) cyc++;
    end
    switches = '0;
    n_checks++; if (cyc != 0) begin n_fail++; $display("FAIL alarm_held: %0d bad cycles want 0", cyc); end
    reset_n = 1'b0;
    tick(1);
    n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_reset: got %0b want 0", alarm); end
    reset_n = 1'b1;
    model_default();
    tick(1);
    entry();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL post_alarm_unlock: got %0b want 0", locked); end
    tick(UNL);
`endif
  endtask

  initial begin
    model_default();
    test_reset();
    test_correct_entry();
    test_wrong_entry();
    test_timeout();
    test_prog_timeout();
    test_programming();
    test_prog_abort();
    test_reset_mid_prog();
    test_held_at_release();
    test_lockout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
